// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding control for a 5-stage in-order pipeline: tracks EX/MEM/WB writers,
// selects operand bypasses for the next EX cycle and inserts one bubble per load-use hazard.
module hazard_fwd_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_a_is_pc,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wen,
    input  logic              id_mem_read,
    input  logic              ex_flush,
    output logic              stall,
    output logic [2:0]        ex_a_sel,
    output logic [2:0]        ex_b_sel,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              mem_read;
    } entry_t;

    typedef enum logic [0:0] {StRun, StStall} state_e;

    localparam logic [1:0] FwdRf  = 2'b00;
    localparam logic [1:0] FwdMem = 2'b10;
    localparam logic [1:0] FwdWb  = 2'b01;

    entry_t     ex_q, mem_q, wb_q;
    state_e     state_q;
    logic       hazard;
    logic [1:0] a_fwd, b_fwd;
    logic [2:0] a_sel_d, b_sel_d;

    function automatic logic produces(entry_t e, logic [REG_AW-1:0] r, logic load_only);
        return e.valid & e.wen & (e.rd == r) & (r != '0) & (e.mem_read | ~load_only);
    endfunction

    function automatic logic [1:0] fwd_sel(logic req, logic [REG_AW-1:0] r,
                                           entry_t ex, entry_t mem, entry_t wb);
        logic [1:0] f;
        f = FwdRf;
        if (!req)                          f = FwdRf;
        else if (produces(ex, r, 1'b0))    f = FwdMem;
        else if (produces(mem, r, 1'b0))   f = FwdWb;
        // write-first register file already returns the value being written back
        else if (produces(wb, r, 1'b0))    f = FwdRf;
        return f;
    endfunction

    always_comb begin
        hazard = id_valid &
                 ((id_use_rs1 & produces(ex_q, id_rs1, 1'b1)) |
                  (id_use_rs2 & produces(ex_q, id_rs2, 1'b1)));
        stall  = ~rst & ~ex_flush & (state_q == StRun) & hazard;

        a_fwd   = id_a_is_pc ? FwdRf : fwd_sel(id_valid & id_use_rs1, id_rs1, ex_q, mem_q, wb_q);
        b_fwd   = fwd_sel(id_valid & id_use_rs2, id_rs2, ex_q, mem_q, wb_q);
        a_sel_d = {id_a_is_pc, a_fwd};
        b_sel_d = {1'b0, b_fwd};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= StRun;
            ex_a_sel    <= 3'b000;
            ex_b_sel    <= 3'b000;
            stall_count <= '0;
        end else begin
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (ex_flush || stall) begin
                ex_q     <= '0;
                ex_a_sel <= 3'b000;
                ex_b_sel <= 3'b000;
            end else begin
                ex_q     <= '{valid: id_valid, rd: id_rd, wen: id_reg_wen, mem_read: id_mem_read};
                ex_a_sel <= a_sel_d;
                ex_b_sel <= b_sel_d;
            end

            if (ex_flush)   state_q <= StRun;
            else if (stall) state_q <= StStall;
            else            state_q <= StRun;

            if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: expected selects/count are queued when an ID
// instruction is driven and compared one clock later.
module tb_hazard_fwd_ctrl;

    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_rs1, id_use_rs2, id_a_is_pc;
    logic          id_reg_wen, id_mem_read, ex_flush;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          stall;
    logic [2:0]    ex_a_sel, ex_b_sel;
    logic [CW-1:0] stall_count;

    typedef struct {
        string      tag;
        logic [2:0] a;
        logic [2:0] b;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_a_is_pc  (id_a_is_pc),
        .id_rd       (id_rd),
        .id_reg_wen  (id_reg_wen),
        .id_mem_read (id_mem_read),
        .ex_flush    (ex_flush),
        .stall       (stall),
        .ex_a_sel    (ex_a_sel),
        .ex_b_sel    (ex_b_sel),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drive ID, check combinational stall, queue the next-cycle result.
    task automatic step(input string tag, input logic v, input logic [4:0] rd, rs1, rs2,
                        input logic u1, u2, pc, wen, mr, fl,
                        input logic es, input logic [2:0] ea, eb);
        exp_t e;
        id_valid = v;   id_rd = rd;     id_rs1 = rs1;    id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_a_is_pc = pc;
        id_reg_wen = wen; id_mem_read = mr; ex_flush = fl;
        #1;
        check({tag, ":stall"}, 32'(stall), 32'(es));
        if (es) exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1;
        sb.push_back('{tag, ea, eb, exp_cnt});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ":a_sel"}, 32'(ex_a_sel), 32'(e.a));
            check({e.tag, ":b_sel"}, 32'(ex_b_sel), 32'(e.b));
            check({e.tag, ":count"}, 32'(stall_count), 32'(e.cnt));
        end
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b1; id_rd = 5'd6; id_rs1 = 5'd5; id_rs2 = 5'd5;
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_a_is_pc = 1'b0;
        id_reg_wen = 1'b1; id_mem_read = 1'b1; ex_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst:a_sel", 32'(ex_a_sel), 32'd0);
        check("rst:b_sel", 32'(ex_b_sel), 32'd0);
        check("rst:count", 32'(stall_count), 32'd0);
        rst = 1'b0;

        //         tag       v  rd  rs1 rs2 u1 u2 pc wen mr fl  stall a       b
        step("post_rst",  1, 6,  5,  5,  1, 1, 0, 1,  0, 0,  0, 3'b000, 3'b000);
        step("addi_x5",   1, 5,  1,  0,  1, 0, 0, 1,  0, 0,  0, 3'b000, 3'b000);
        step("ex_fwd",    1, 6,  5,  5,  1, 1, 0, 1,  0, 0,  0, 3'b010, 3'b010);
        step("nop0",      0, 0,  0,  0,  0, 0, 0, 0,  0, 0,  0, 3'b000, 3'b000);
        step("addi_x5b",  1, 5,  0,  0,  1, 0, 0, 1,  0, 0,  0, 3'b000, 3'b000);
        step("nop1",      0, 0,  0,  0,  0, 0, 0, 0,  0, 0,  0, 3'b000, 3'b000);
        step("mem_fwd",   1, 6,  5,  7,  1, 1, 0, 1,  0, 0,  0, 3'b001, 3'b000);
        step("addi_x5c",  1, 5,  1,  0,  1, 0, 0, 1,  0, 0,  0, 3'b000, 3'b000);
        step("addi_x5d",  1, 5,  1,  0,  1, 0, 0, 1,  0, 0,  0, 3'b000, 3'b000);
        step("ex_wins",   1, 8,  5,  5,  1, 1, 0, 1,  0, 0,  0, 3'b010, 3'b010);
        step("nop2",      0, 0,  0,  0,  0, 0, 0, 0,  0, 0,  0, 3'b000, 3'b000);
        step("nop3",      0, 0,  0,  0,  0, 0, 0, 0,  0, 0,  0, 3'b000, 3'b000);
        step("wb_rf",     1, 9,  8,  8,  1, 1, 0, 1,  0, 0,  0, 3'b000, 3'b000);
        step("unused",    1, 10, 9,  9,  0, 0, 0, 1,  0, 0,  0, 3'b000, 3'b000);
        step("addi_x0",   1, 0,  0,  0,  1, 0, 0, 1,  0, 0,  0, 3'b000, 3'b000);
        step("x0_nofwd",  1, 6,  0,  0,  1, 1, 0, 1,  0, 0,  0, 3'b000, 3'b000);
        step("jal",       1, 1,  0,  0,  0, 0, 1, 1,  0, 0,  0, 3'b100, 3'b000);
        step("pc_b_fwd",  1, 3,  1,  1,  0, 1, 1, 1,  0, 0,  0, 3'b100, 3'b010);
        step("lw_x5",     1, 5,  2,  0,  1, 0, 0, 1,  1, 0,  0, 3'b000, 3'b000);
        step("ld_use",    1, 6,  5,  1,  1, 1, 0, 1,  0, 0,  1, 3'b000, 3'b000);
        step("ld_replay", 1, 6,  5,  1,  1, 1, 0, 1,  0, 0,  0, 3'b001, 3'b000);
        step("lw_x7",     1, 7,  2,  0,  1, 0, 0, 1,  1, 0,  0, 3'b000, 3'b000);
        step("ld_indep",  1, 8,  1,  2,  1, 1, 0, 1,  0, 0,  0, 3'b000, 3'b000);
        step("lw_x5b",    1, 5,  2,  0,  1, 0, 0, 1,  1, 0,  0, 3'b000, 3'b000);
        step("ld_flush",  1, 6,  5,  5,  1, 1, 0, 1,  0, 1,  0, 3'b000, 3'b000);
        step("mem_adv",   1, 9,  5,  0,  1, 1, 0, 1,  0, 0,  0, 3'b001, 3'b000);
        step("addi_x4",   1, 4,  1,  0,  1, 0, 0, 1,  0, 0,  0, 3'b000, 3'b000);
        step("flush_alu", 1, 11, 4,  0,  1, 1, 0, 1,  0, 1,  0, 3'b000, 3'b000);
        step("post_fl",   1, 12, 4,  11, 1, 1, 0, 1,  0, 0,  0, 3'b001, 3'b000);
        step("lw_x5c",    1, 5,  2,  0,  1, 0, 0, 1,  1, 0,  0, 3'b000, 3'b000);
        step("ld_use2",   1, 6,  5,  5,  1, 1, 0, 1,  0, 0,  1, 3'b000, 3'b000);

        // Reset while the FSM sits in STALL
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_stall:a_sel", 32'(ex_a_sel), 32'd0);
        check("rst_stall:b_sel", 32'(ex_b_sel), 32'd0);
        check("rst_stall:count", 32'(stall_count), 32'd0);
        rst = 1'b0;
        exp_cnt = 0;
        step("after_rst", 1, 6,  5,  5,  1, 1, 0, 1,  0, 0,  0, 3'b000, 3'b000);

        // Saturation: more hazards than the counter can hold
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            step("sat_lw",   1, 5, 2, 0, 1, 0, 0, 1, 1, 0,  0, 3'b000, 3'b000);
            step("sat_use",  1, 6, 5, 5, 1, 1, 0, 1, 0, 0,  1, 3'b000, 3'b000);
            step("sat_rep",  1, 6, 5, 5, 1, 1, 0, 1, 0, 0,  0, 3'b001, 3'b001);
        end
        check("sat_final", 32'(stall_count), 32'(CMAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  decode stage holds a real instruction.
REQ-006 id_rs1, id_rs2  input  REG_AW each  decode source register addresses.
REQ-007 id_use_rs1, id_use_rs2  input  1 each  instruction actually reads rs1 / rs2.
REQ-008 id_a_is_pc  input  1  operand A is the PC rather than rs1.
REQ-009 id_rd  input  REG_AW  decode destination register.
REQ-010 id_reg_wen  input  1  instruction writes rd.
REQ-011 id_mem_read  input  1  instruction is a load.
REQ-012 ex_flush  input  1  branch/jump resolved taken in EX; kill ID and EX.
REQ-013 stall  output  1  combinational; hold PC and IF/ID this cycle.
REQ-014 ex_a_sel  output  3  registered {pc_sel, fwd[1:0]} driving the operand-A mux.
REQ-015 ex_b_sel  output  3  registered {0, fwd[1:0]} driving the operand-B mux.
REQ-016 stall_count  output  CNT_W  saturating count of load-use stall cycles.

Function
REQ-017 fwd encoding SHALL be 00 = register file, 10 = MEM-stage ALU result, 01 = WB-stage result; code 11 SHALL never be produced.
REQ-018 Block SHALL keep shadow tracking entries {valid, rd, wen, mem_read} for EX, MEM and WB, advanced every cycle EX->MEM->WB.
REQ-019 On a non-stall, non-flush cycle, EX entry SHALL load {id_valid, id_rd, id_reg_wen, id_mem_read}.
REQ-020 A tracking entry "produces r" iff valid & wen & rd == r & r != 0.
REQ-021 For each used source r of a valid ID instruction: EX entry produces r -> fwd 10; else MEM entry produces r -> fwd 01; else 00 (the EX producer, being younger, wins).
REQ-022 A WB-stage producer at ID time SHALL yield fwd 00; the register file is write-first.
REQ-023 Register x0 SHALL never be forwarded; unused sources SHALL yield fwd 00.
REQ-024 pc_sel bit of ex_a_sel SHALL equal registered id_a_is_pc; with pc_sel=1 the fwd bits of ex_a_sel SHALL be 00.
REQ-025 Load-use: stall SHALL be 1 when id_valid, EX entry is a load, and it produces a used source of ID.
REQ-026 States: RUN and STALL. RUN->STALL on a load-use hazard; STALL->RUN unconditionally next cycle (exactly one bubble per hazard).
REQ-027 In STALL-entry cycle, EX entry and ex_a_sel/ex_b_sel SHALL load a bubble (valid=0, sel=000); ID is re-evaluated next cycle, when the load sits in MEM and the consumer gets fwd 01.
REQ-028 stall SHALL be 0 in the STALL state; no second stall can occur for the same instruction.
REQ-029 ex_flush SHALL override: stall forced 0, EX entry and selects load a bubble, FSM -> RUN; MEM/WB entries advance normally.
REQ-030 ex_flush coincident with a load-use hazard SHALL produce no stall and no count increment.
REQ-031 stall_count SHALL increment by 1 per cycle stall=1 and saturate at all-ones.
REQ-032 Latency: selects computed from ID inputs appear on ex_a_sel/ex_b_sel one cycle later.

Reset
REQ-033 While rst=1 at a clock edge: all tracking entries invalid, FSM = RUN, ex_a_sel = ex_b_sel = 000, stall_count = 0.
REQ-034 stall SHALL be 0 in the cycle after reset regardless of ID inputs; reset mid-stall SHALL abandon the stall.

Verification
REQ-035 addi x5 then add x6,x5,x5 back-to-back -> next cycle ex_a_sel=010, ex_b_sel=010, stall=0.
REQ-036 addi x5; nop; add x6,x5,x7 -> ex_a_sel=001, ex_b_sel=000.
REQ-037 lw x5 then add x6,x5,x1 -> stall=1 one cycle, bubble (sel 000) into EX, then ex_a_sel=001; stall_count=1.
REQ-038 addi x0,x0,1 then add x6,x0,x0 -> selects 000; jal with id_a_is_pc=1 -> ex_a_sel=100.
REQ-039 lw x5 then dependent add with ex_flush=1 same cycle -> stall=0, EX bubble, stall_count unchanged.
REQ-040 rst asserted during STALL -> next cycle selects 000, stall_count=0, FSM RUN; 2^CNT_W+3 hazards -> stall_count stays at all-ones.
